// File: rtl/march_element_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : march_element_sequencer
// Description : Walks the address counter through one march element of a
//               memory BIST algorithm. It loads the first or last address,
//               issues 1-4 operation slots per address over a valid/ready
//               handshake, steps the counter, detects the final address and
//               pulses done_out when the element completes.
// Ports       : clk, rst (async, active-high)
//               start_in/abort_in      - element control from the controller
//               dir_in/nops_in/admd_in - element setup, latched at start
//               op_ready_in            - downstream accepts the current slot
//               s_out/r_out/hold_out/updwn_out/admd_out - counter controls
//               op_valid_out/op_idx_out - operation slot handshake
//               last_addr_out/busy_out/done_out - element status
// Revision    : 1.0 - initial release
// ============================================================================
module march_element_sequencer #(
    parameter int              TASW      = 8,     // address width
    parameter int              ADMW      = 3,     // address-mode field width
    parameter logic            ADDR_UP   = 1'b1,  // direction encoding for "up"
    parameter logic [ADMW-1:0] ADMD_PRUD = ADMW'(2) // pseudo-random (LFSR) mode
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic            abort_in,
    input  logic            dir_in,
    input  logic [1:0]      nops_in,
    input  logic [ADMW-1:0] admd_in,
    input  logic            op_ready_in,
    output logic            s_out,
    output logic            r_out,
    output logic            hold_out,
    output logic            updwn_out,
    output logic [ADMW-1:0] admd_out,
    output logic            op_valid_out,
    output logic [1:0]      op_idx_out,
    output logic            last_addr_out,
    output logic            busy_out,
    output logic            done_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_OPS  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [TASW-1:0]   r_step_cnt;
    logic [1:0]        r_op_cnt;
    logic [1:0]        r_nops;
    logic              r_updwn;
    logic [ADMW-1:0]   r_admd;
    logic              r_s;
    logic              r_r;
    logic              r_hold;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [TASW-1:0]   w_terminal;
    logic              w_last;

    // The LFSR mode cycles through 2^TASW-1 states, so it ends one step early.
    assign w_terminal = (r_admd == ADMD_PRUD) ? {{(TASW-1){1'b1}}, 1'b0}
                                              : {TASW{1'b1}};
    assign w_last     = (r_step_cnt == w_terminal) && r_busy;

    // Outputs are registered for the state being entered, so they line up
    // with r_state without any input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step_cnt <= '0;
            r_op_cnt   <= '0;
            r_nops     <= '0;
            r_updwn    <= ADDR_UP;
            r_admd     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_hold     <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            r_s    <= 1'b0;
            r_r    <= 1'b0;
            r_done <= 1'b0;

            if (r_state != S_IDLE && abort_in) begin
                r_state  <= S_IDLE;
                r_op_cnt <= '0;
                r_hold   <= 1'b1;
                r_valid  <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_hold  <= 1'b1;
                        r_valid <= 1'b0;
                        if (start_in && !abort_in) begin
                            r_updwn    <= dir_in;
                            r_nops     <= nops_in;
                            r_admd     <= admd_in;
                            r_step_cnt <= '0;
                            r_op_cnt   <= '0;
                            r_state    <= S_LOAD;
                            r_hold     <= 1'b0;
                            r_s        <= (dir_in == ADDR_UP);
                            r_r        <= (dir_in != ADDR_UP);
                            r_busy     <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_OPS;
                        r_hold  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                    S_OPS: begin
                        if (op_ready_in) begin
                            if (r_op_cnt < r_nops) begin
                                r_op_cnt <= r_op_cnt + 2'd1;
                            end else if (w_last) begin
                                r_state <= S_DONE;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_STEP;
                                r_valid <= 1'b0;
                                r_hold  <= 1'b0;
                            end
                        end
                    end
                    S_STEP: begin
                        // Terminal is never reached here, so no wrap guard.
                        r_step_cnt <= r_step_cnt + 1'b1;
                        r_op_cnt   <= '0;
                        r_state    <= S_OPS;
                        r_hold     <= 1'b1;
                        r_valid    <= 1'b1;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_hold  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_hold  <= 1'b1;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_out         = r_s;
    assign r_out         = r_r;
    assign hold_out      = r_hold;
    assign updwn_out     = r_updwn;
    assign admd_out      = r_admd;
    assign op_valid_out  = r_valid;
    assign op_idx_out    = r_op_cnt;
    assign last_addr_out = w_last;
    assign busy_out      = r_busy;
    assign done_out      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_march_element_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_march_element_sequencer
// Description : Directed self-checking bench for march_element_sequencer.
//               Expected operation slots are queued when an element starts
//               and popped as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_march_element_sequencer;

    localparam int         TASW  = 8;
    localparam int         ADMW  = 3;
    localparam logic       UP    = 1'b1;
    localparam logic       DOWN  = 1'b0;
    localparam logic [2:0] LIN   = 3'd0;
    localparam logic [2:0] PRUD  = 3'd2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_in = 1'b0;
    logic            abort_in = 1'b0;
    logic            dir_in = UP;
    logic [1:0]      nops_in = 2'd0;
    logic [ADMW-1:0] admd_in = '0;
    logic            op_ready_in = 1'b1;
    logic            s_out, r_out, hold_out, updwn_out;
    logic [ADMW-1:0] admd_out;
    logic            op_valid_out;
    logic [1:0]      op_idx_out;
    logic            last_addr_out, busy_out, done_out;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
    } slot_t;
    slot_t sb[$];

    always #5 clk = ~clk;

    march_element_sequencer #(
        .TASW(TASW), .ADMW(ADMW), .ADDR_UP(UP), .ADMD_PRUD(PRUD)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
        .dir_in(dir_in), .nops_in(nops_in), .admd_in(admd_in),
        .op_ready_in(op_ready_in), .s_out(s_out), .r_out(r_out),
        .hold_out(hold_out), .updwn_out(updwn_out), .admd_out(admd_out),
        .op_valid_out(op_valid_out), .op_idx_out(op_idx_out),
        .last_addr_out(last_addr_out), .busy_out(busy_out), .done_out(done_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " hold"},  32'(hold_out), 32'd1);
        chk({tag, " s"},     32'(s_out), 32'd0);
        chk({tag, " r"},     32'(r_out), 32'd0);
        chk({tag, " updwn"}, 32'(updwn_out), 32'(UP));
        chk({tag, " admd"},  32'(admd_out), 32'd0);
        chk({tag, " valid"}, 32'(op_valid_out), 32'd0);
        chk({tag, " idx"},   32'(op_idx_out), 32'd0);
        chk({tag, " last"},  32'(last_addr_out), 32'd0);
        chk({tag, " busy"},  32'(busy_out), 32'd0);
        chk({tag, " done"},  32'(done_out), 32'd0);
    endtask

    // Runs one element. stall_addr: address whose op_idx=1 slot is stalled
    // for 3 cycles (-1 none). abort_addr: abort when that address is first
    // offered (-1 none). exp_done: cycle of the done pulse, edge 0 = start.
    task automatic run_elem(input string tag, input logic dir, input logic [1:0] nops,
                            input logic [2:0] admd, input int stall_addr,
                            input int abort_addr, input int exp_done);
        int    n_addr;
        int    addr;
        int    stall_left;
        bit    stalled;
        bit    aborted;
        int    done_cyc;
        int    done_cnt;
        int    hold_low;
        slot_t exp_s;
        n_addr = (admd == PRUD) ? 255 : 256;
        sb.delete();
        for (int a = 0; a < n_addr; a++)
            for (int k = 0; k <= int'(nops); k++)
                sb.push_back('{idx: 2'(k), last: (a == n_addr - 1)});
        addr = 0; stall_left = 0; stalled = 0; aborted = 0;
        done_cyc = -1; done_cnt = 0; hold_low = 0;

        @(negedge clk);
        dir_in = dir; nops_in = nops; admd_in = admd;
        start_in = 1'b1; abort_in = 1'b0; op_ready_in = 1'b1;
        @(posedge clk);  // edge 0
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            @(negedge clk);
            start_in = 1'b0;
            dir_in   = dir;
            if (cyc == 50) begin  // start while busy, with the other direction
                start_in = 1'b1;
                dir_in   = ~dir;
            end
            if (cyc == 1) begin
                chk({tag, " s_pulse"}, 32'(s_out), 32'(dir == UP));
                chk({tag, " r_pulse"}, 32'(r_out), 32'(dir != UP));
                chk({tag, " load_hold"}, 32'(hold_out), 32'd0);
            end
            if (!hold_out) hold_low++;
            if (done_out) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_addr >= 0 && op_valid_out && addr == abort_addr) begin
                abort_in = 1'b1;
                aborted  = 1'b1;
                break;
            end
            if (op_valid_out && addr == stall_addr && op_idx_out == 2'd1 && !stalled) begin
                stalled    = 1'b1;
                stall_left = 3;
            end
            op_ready_in = (stall_left == 0);
            if (op_valid_out) begin
                if (sb.size() == 0) begin
                    chk({tag, " sb_underflow"}, 32'd1, 32'd0);
                end else begin
                    exp_s = sb[0];
                    if (stall_left > 0) begin
                        chk({tag, " stall_idx"},  32'(op_idx_out), 32'(exp_s.idx));
                        chk({tag, " stall_hold"}, 32'(hold_out), 32'd1);
                        stall_left--;
                    end else begin
                        exp_s = sb.pop_front();
                        chk({tag, " idx"},  32'(op_idx_out), 32'(exp_s.idx));
                        chk({tag, " last"}, 32'(last_addr_out), 32'(exp_s.last));
                        if (exp_s.idx == nops) addr++;
                    end
                end
            end
        end
        op_ready_in = 1'b1;
        if (aborted) begin
            @(negedge clk);
            abort_in = 1'b0;
            chk({tag, " abort_busy"},  32'(busy_out), 32'd0);
            chk({tag, " abort_valid"}, 32'(op_valid_out), 32'd0);
            chk({tag, " abort_hold"},  32'(hold_out), 32'd1);
            chk({tag, " abort_done"},  32'(done_out | 1'(done_cnt != 0)), 32'd0);
        end else begin
            chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
            chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
            chk({tag, " hold_low"},   32'(hold_low), 32'(n_addr));
            chk({tag, " sb_empty"},   32'(sb.size()), 32'd0);
            chk({tag, " busy_after"}, 32'(busy_out), 32'd0);
            chk({tag, " updwn"},      32'(updwn_out), 32'(dir));
            chk({tag, " admd"},       32'(admd_out), 32'(admd));
        end
    endtask

    initial begin
        int waited;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // start together with abort in IDLE is ignored
        start_in = 1'b1; abort_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0; abort_in = 1'b0;
        chk("start_abort busy", 32'(busy_out), 32'd0);
        chk("start_abort s",    32'(s_out), 32'd0);

        run_elem("lin_up",   UP,   2'd0, LIN,  -1, -1, 513);
        run_elem("lin_down", DOWN, 2'd1, LIN,  -1, -1, 769);
        run_elem("prud_up",  UP,   2'd0, PRUD, -1, -1, 511);
        run_elem("stall",    UP,   2'd1, LIN,   5, -1, 772);
        run_elem("abort",    UP,   2'd0, LIN,  -1, 10, 600);
        run_elem("restart",  UP,   2'd0, LIN,  -1, -1, 513);

        // asynchronous reset in the middle of a STEP cycle
        @(negedge clk);
        dir_in = UP; nops_in = 2'd0; admd_in = LIN; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        waited = 0;
        while (!(busy_out && !hold_out && !s_out && !r_out) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_step_found", 32'(waited < 20), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
